// File: rtl/sram_arbiter.sv
// Two-master (instruction/data) arbiter onto one pipelined SRAM-style slave port.
// Data master has priority; a request stalled by the slave stays with its master
// until it is accepted. Responses return in order and are routed by a small
// FIFO of master ids, one entry per accepted transaction.
module sram_arbiter #(
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic        resp_err
);

  localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(OUTSTANDING);

  typedef enum logic [1:0] {
    ARB_OPEN      = 2'd0,
    ARB_HOLD_INST = 2'd1,
    ARB_HOLD_DATA = 2'd2
  } arb_state_t;

  arb_state_t     state, state_nxt;

  logic           gnt_valid;
  logic           gnt_data;
  logic           gnt_req;
  logic           push;
  logic           pop;
  logic           head;

  logic [CW-1:0]  count;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           order_q [OUTSTANDING];

  // Lock register: remembers which master owns a request the slave has not yet accepted.
  always_ff @(posedge clk) begin
    if (reset) state <= ARB_OPEN;
    else       state <= state_nxt;
  end

  // Grant selection, slave request mux, lock next-state and handshake decode.
  always_comb begin
    gnt_valid    = 1'b0;
    gnt_data     = 1'b0;
    gnt_req      = 1'b0;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = '0;
    mem_wstrb    = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    push         = 1'b0;
    pop          = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    state_nxt    = state;

    unique case (state)
      ARB_HOLD_INST: begin
        gnt_valid = 1'b1;
        gnt_data  = 1'b0;
      end
      ARB_HOLD_DATA: begin
        gnt_valid = 1'b1;
        gnt_data  = 1'b1;
      end
      default: begin
        if (data_req) begin
          gnt_valid = 1'b1;
          gnt_data  = 1'b1;
        end else if (inst_req) begin
          gnt_valid = 1'b1;
          gnt_data  = 1'b0;
        end
      end
    endcase

    if (gnt_valid) begin
      if (gnt_data) begin
        gnt_req   = data_req;
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        gnt_req   = inst_req;
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_wstrb = inst_wstrb;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
      end
    end

    mem_req = gnt_req && (count < FULL_CNT);
    push    = mem_req && mem_addr_ok;
    pop     = mem_data_ok && (count != '0);

    inst_addr_ok = push && !gnt_data;
    data_addr_ok = push &&  gnt_data;
    inst_data_ok = pop  && !head;
    data_data_ok = pop  &&  head;

    if (push)
      state_nxt = ARB_OPEN;
    else if (mem_req)
      state_nxt = gnt_data ? ARB_HOLD_DATA : ARB_HOLD_INST;
  end

  assign head       = order_q[rd_ptr];
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  // Order FIFO storage: master id of each accepted transaction.
  always_ff @(posedge clk) begin
    if (push) order_q[wr_ptr] <= gnt_data;
  end

  // FIFO pointers, occupancy and the sticky unexpected-response flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      resp_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (mem_data_ok && (count == '0)) resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a cycle-sequence table plus hand-written
// sequences for full stall, pointer wrap and reset with transactions in flight.
module tb_sram_arbiter;

  localparam logic [31:0] IADDR  = 32'h1000_0004;
  localparam logic [31:0] DADDR  = 32'h2000_0008;
  localparam logic [31:0] IWDATA = 32'hAAAA_0001;
  localparam logic [31:0] DWDATA = 32'hBBBB_0002;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        resp_err;

  int errors = 0;
  int checks = 0;

  sram_arbiter #(.OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // gnt: 0 none, 1 inst, 2 data
  typedef struct {
    logic        ireq, dreq, aok, dok;
    logic [31:0] rdata;
    logic        mreq;
    logic [1:0]  gnt;
    logic        iaok, daok, idok, ddok, err;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(input logic ireq, dreq, aok, dok, input logic [31:0] rdata,
                              input logic mreq, input logic [1:0] gnt,
                              input logic iaok, daok, idok, ddok, err);
    vec_t v;
    v.ireq = ireq; v.dreq = dreq; v.aok = aok; v.dok = dok; v.rdata = rdata;
    v.mreq = mreq; v.gnt = gnt; v.iaok = iaok; v.daok = daok;
    v.idok = idok; v.ddok = ddok; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, then advance past the edge.
  task automatic step(input string name, input logic ireq, dreq, aok, dok, input logic [31:0] rdata,
                      input logic mreq, input logic [1:0] gnt,
                      input logic iaok, daok, idok, ddok, err);
    inst_req    = ireq;
    data_req    = dreq;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rdata;
    #2;
    chk({name, ".mem_req"},   32'(mem_req),   32'(mreq));
    chk({name, ".mem_addr"},  mem_addr,  gnt == 2'd2 ? DADDR  : gnt == 2'd1 ? IADDR  : 32'h0);
    chk({name, ".mem_wdata"}, mem_wdata, gnt == 2'd2 ? DWDATA : gnt == 2'd1 ? IWDATA : 32'h0);
    chk({name, ".mem_wr"},    32'(mem_wr),    32'(gnt == 2'd2));
    chk({name, ".mem_wstrb"}, 32'(mem_wstrb), gnt == 2'd2 ? 32'h3 : gnt == 2'd1 ? 32'hf : 32'h0);
    chk({name, ".inst_addr_ok"}, 32'(inst_addr_ok), 32'(iaok));
    chk({name, ".data_addr_ok"}, 32'(data_addr_ok), 32'(daok));
    chk({name, ".inst_data_ok"}, 32'(inst_data_ok), 32'(idok));
    chk({name, ".data_data_ok"}, 32'(data_data_ok), 32'(ddok));
    chk({name, ".inst_rdata"},   inst_rdata, rdata);
    chk({name, ".data_rdata"},   data_rdata, rdata);
    chk({name, ".resp_err"},     32'(resp_err), 32'(err));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  bit pushd [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  bit popd  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    inst_wr = 1'b0; inst_size = 2'b10; inst_wstrb = 4'hf; inst_addr = IADDR; inst_wdata = IWDATA;
    data_wr = 1'b1; data_size = 2'b01; data_wstrb = 4'h3; data_addr = DADDR; data_wdata = DWDATA;
    do_reset();

    //            ireq dreq aok dok rdata       mreq gnt  ia da id dd err
    vt[0]  = mk(1, 1, 1, 0, 32'h0,    1, 2'd2, 0, 1, 0, 0, 0);
    vt[1]  = mk(1, 0, 1, 0, 32'h0,    1, 2'd1, 1, 0, 0, 0, 0);
    vt[2]  = mk(0, 0, 0, 1, 32'h11,   0, 2'd0, 0, 0, 0, 1, 0);
    vt[3]  = mk(0, 0, 0, 1, 32'h22,   0, 2'd0, 0, 0, 1, 0, 0);
    vt[4]  = mk(1, 0, 0, 0, 32'h0,    1, 2'd1, 0, 0, 0, 0, 0);
    vt[5]  = mk(1, 1, 0, 0, 32'h0,    1, 2'd1, 0, 0, 0, 0, 0);
    vt[6]  = mk(1, 1, 0, 0, 32'h0,    1, 2'd1, 0, 0, 0, 0, 0);
    vt[7]  = mk(1, 1, 1, 0, 32'h0,    1, 2'd1, 1, 0, 0, 0, 0);
    vt[8]  = mk(0, 1, 1, 0, 32'h0,    1, 2'd2, 0, 1, 0, 0, 0);
    vt[9]  = mk(0, 0, 0, 1, 32'h33,   0, 2'd0, 0, 0, 1, 0, 0);
    vt[10] = mk(0, 0, 0, 1, 32'h44,   0, 2'd0, 0, 0, 0, 1, 0);
    vt[11] = mk(0, 0, 0, 1, 32'h55,   0, 2'd0, 0, 0, 0, 0, 0);
    vt[12] = mk(0, 0, 0, 0, 32'h0,    0, 2'd0, 0, 0, 0, 0, 1);

    step("rst", 0, 0, 0, 0, 32'h0, 0, 2'd0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++)
      step($sformatf("vec%0d", i), vt[i].ireq, vt[i].dreq, vt[i].aok, vt[i].dok, vt[i].rdata,
           vt[i].mreq, vt[i].gnt, vt[i].iaok, vt[i].daok, vt[i].idok, vt[i].ddok, vt[i].err);

    // In-order routing of an interleaved inst,data,inst stream
    do_reset();
    step("ord.rst", 0, 0, 0, 0, 32'h0,  0, 2'd0, 0, 0, 0, 0, 0);
    step("ord.i0",  1, 0, 1, 0, 32'h0,  1, 2'd1, 1, 0, 0, 0, 0);
    step("ord.d1",  0, 1, 1, 0, 32'h0,  1, 2'd2, 0, 1, 0, 0, 0);
    step("ord.i2",  1, 0, 1, 0, 32'h0,  1, 2'd1, 1, 0, 0, 0, 0);
    step("ord.r0",  0, 0, 0, 1, 32'h11, 0, 2'd0, 0, 0, 1, 0, 0);
    step("ord.r1",  0, 0, 0, 1, 32'h22, 0, 2'd0, 0, 0, 0, 1, 0);
    step("ord.r2",  0, 0, 0, 1, 32'h33, 0, 2'd0, 0, 0, 1, 0, 0);

    // Full stall: four accepted, fifth held off even with a response in the same cycle
    for (int i = 0; i < 4; i++)
      step($sformatf("full.d%0d", i), 0, 1, 1, 0, 32'h0, 1, 2'd2, 0, 1, 0, 0, 0);
    step("full.stall",  0, 1, 1, 0, 32'h0,  0, 2'd2, 0, 0, 0, 0, 0);
    step("full.popst",  0, 1, 1, 1, 32'h66, 0, 2'd2, 0, 0, 0, 1, 0);
    step("full.resume", 0, 1, 1, 0, 32'h0,  1, 2'd2, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step($sformatf("full.r%0d", i), 0, 0, 0, 1, 32'(i + 1), 0, 2'd0, 0, 0, 0, 1, 0);

    // Simultaneous push/pop at occupancy 2 across pointer wrap
    step("wrap.p0", 1, 0, 1, 0, 32'h0, 1, 2'd1, 1, 0, 0, 0, 0);
    step("wrap.p1", 0, 1, 1, 0, 32'h0, 1, 2'd2, 0, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++)
      step($sformatf("wrap.s%0d", k), !pushd[k], pushd[k], 1, 1, 32'(k + 8'h80),
           1, pushd[k] ? 2'd2 : 2'd1, !pushd[k], pushd[k], !popd[k], popd[k], 0);
    step("wrap.r0",  0, 0, 0, 1, 32'h90, 0, 2'd0, 0, 0, 0, 1, 0);
    step("wrap.r1",  0, 0, 0, 1, 32'h91, 0, 2'd0, 0, 0, 1, 0, 0);
    step("wrap.spr", 0, 0, 0, 1, 32'h92, 0, 2'd0, 0, 0, 0, 0, 0);
    step("wrap.err", 0, 0, 0, 0, 32'h0,  0, 2'd0, 0, 0, 0, 0, 1);

    // Reset discards in-flight transactions; their late responses are errors
    do_reset();
    step("rmid.rst0", 0, 0, 0, 0, 32'h0,  0, 2'd0, 0, 0, 0, 0, 0);
    step("rmid.i0",   1, 0, 1, 0, 32'h0,  1, 2'd1, 1, 0, 0, 0, 0);
    step("rmid.i1",   1, 0, 1, 0, 32'h0,  1, 2'd1, 1, 0, 0, 0, 0);
    do_reset();
    step("rmid.late", 0, 0, 0, 1, 32'h77, 0, 2'd0, 0, 0, 0, 0, 0);
    step("rmid.err",  0, 0, 0, 0, 32'h0,  0, 2'd0, 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: OUTSTANDING, default 4, max accepted-but-unanswered transactions (power of two, >=2).
REQ-002 clk  input  1  single clock; all state on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inst_req / inst_wr  input  1/1  instruction master request, write flag.
REQ-005 inst_size / inst_wstrb  input  2/4  access size (00 byte, 01 half, 10 word), byte strobe.
REQ-006 inst_addr / inst_wdata  input  32/32  instruction master address, write data.
REQ-007 inst_addr_ok / inst_data_ok  output  1/1  request accepted, response valid, instruction master.
REQ-008 inst_rdata  output  32  read data, instruction master.
REQ-009 data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  input  1,1,2,4,32,32  data master request fields, same meaning as inst_*.
REQ-010 data_addr_ok / data_data_ok  output  1/1; data_rdata  output  32  data master handshake and read data.
REQ-011 mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  output  1,1,2,4,32,32  shared slave request port.
REQ-012 mem_addr_ok / mem_data_ok  input  1/1; mem_rdata  input  32  slave handshake and read data.
REQ-013 resp_err  output  1  sticky: mem_data_ok seen with no outstanding transaction.

Function
REQ-014 Request handshake occurs in a cycle where mem_req && mem_addr_ok; response handshake in a cycle where mem_data_ok.
REQ-015 Grant: if lock valid, grant = locked id; else data master if data_req, else inst master if inst_req, else none.
REQ-016 mem_req = granted master's req && (count < OUTSTANDING); all mem_* request fields combinationally mux the granted master's fields; fields zero when no grant.
REQ-017 Lock set (id = current grant) in a cycle where mem_req && !mem_addr_ok; cleared on the request handshake; a pending request is never re-granted to the other master mid-wait.
REQ-018 inst_addr_ok = mem_addr_ok && mem_req && grant==inst; data_addr_ok likewise for data; never both in one cycle.
REQ-019 Order FIFO, depth OUTSTANDING, 1-bit entries (0 inst, 1 data): push grant id on request handshake; pop head on mem_data_ok when count>0.
REQ-020 count width log2(OUTSTANDING)+1; push-only +1, pop-only -1, push and pop same cycle: count unchanged, read/write pointers both advance, wrap modulo OUTSTANDING.
REQ-021 Full (count==OUTSTANDING): mem_req held low regardless of simultaneous mem_data_ok; lock unaffected.
REQ-022 Response routing: inst_data_ok = mem_data_ok && count>0 && head==0; data_data_ok = mem_data_ok && count>0 && head==1; both rdata outputs = mem_rdata unconditionally.
REQ-023 Responses return strictly in request order; slave asserts mem_data_ok no earlier than the cycle after the matching mem_addr_ok.
REQ-024 mem_data_ok with count==0: no *_data_ok, no pointer/count change, resp_err set to 1 and held until reset.
REQ-025 Zero added latency: request and response paths purely combinational from registered state; no stall beyond REQ-021.
REQ-026 Writes occupy a FIFO entry identically to reads; data_ok returned for both.

Reset
REQ-027 In a reset cycle: count=0, pointers=0, lock cleared, resp_err=0; outputs thereafter follow REQ-016..022 (mem_req low unless a master requests).
REQ-028 Reset mid-transaction discards all outstanding entries; later mem_data_ok for them raises resp_err.

Verification
REQ-029 inst_req and data_req both high, mem_addr_ok=1 -> data_addr_ok=1, inst_addr_ok=0, mem_addr=data_addr; next cycle inst granted.
REQ-030 inst_req alone, mem_addr_ok low 3 cycles, data_req rises cycle 2 -> mem_addr stays inst_addr until handshake cycle 4, then data granted.
REQ-031 Issue 4 data reads without mem_data_ok -> count=4, mem_req=0 on 5th request; one mem_data_ok -> data_data_ok=1, mem_req=1 next cycle.
REQ-032 Interleaved order inst,data,inst accepted; three mem_data_ok with rdata 0x11,0x22,0x33 -> inst_data_ok/0x11, data_data_ok/0x22, inst_data_ok/0x33.
REQ-033 count=2, push and pop same cycle 6 times -> count stays 2, correct head routing across pointer wrap.
REQ-034 mem_data_ok with count=0, and after reset with 2 outstanding -> resp_err=1, no *_data_ok pulse.
